// File: rtl/button_event_arbiter.sv
// Serialises single-cycle button event pulses onto one valid/ready channel
// with round-robin arbitration and sticky per-input overrun flags.

module button_event_lane (
  input  logic clock,
  input  logic reset,
  input  logic pulse,
  input  logic take,
  input  logic clear_overrun,
  output logic pending,
  output logic overrun
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A fresh pulse re-arms the latch even while its old event moves to the slot.
      if (pulse)     pending <= 1'b1;
      else if (take) pending <= 1'b0;
      // A set in the same cycle wins over clear.
      if (pulse && pending && !take) overrun <= 1'b1;
      else if (clear_overrun)        overrun <= 1'b0;
    end
  end

endmodule

module button_event_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] pulse_in,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] id,
  output logic [N-1:0] overrun,
  input  logic         clear_overrun
);

  logic [N-1:0] pending;
  logic [N-1:0] take;
  logic [W-1:0] ptr;
  logic [W-1:0] sel;
  logic         sel_any;
  logic         load;

  assign load = !valid || ready;

  // First set pending bit at or after ptr, wrapping at N.
  always_comb begin
    int idx;
    sel_any = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!sel_any && pending[idx[W-1:0]]) begin
        sel_any = 1'b1;
        sel     = idx[W-1:0];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign take[i] = load && sel_any && (sel == W'(i));
    button_event_lane u_lane (
      .clock         (clock),
      .reset         (reset),
      .pulse         (pulse_in[i]),
      .take          (take[i]),
      .clear_overrun (clear_overrun),
      .pending       (pending[i]),
      .overrun       (overrun[i])
    );
  end

  // Output slot: valid is the FSM state (EMPTY/FULL); id holds while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      id    <= '0;
      ptr   <= '0;
    end else if (load) begin
      valid <= sel_any;
      if (sel_any) begin
        id  <= sel;
        ptr <= (sel == W'(N - 1)) ? '0 : sel + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: a behavioural model compared every
// cycle, plus literal expectations along the directed scenarios.

module tb_button_event_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] pulse_in = '0;
  logic         ready = 1'b0;
  logic         clear_overrun = 1'b0;
  logic         valid;
  logic [W-1:0] id;
  logic [N-1:0] overrun;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  button_event_arbiter #(.N(N), .W(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .pulse_in      (pulse_in),
    .ready         (ready),
    .valid         (valid),
    .id            (id),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  always #5 clock = ~clock;

  // Model: event latches as an int array, slot as (m_valid, m_id), rr start index.
  int m_pend [N];
  int m_valid, m_id, m_ptr;
  int m_ovr [N];

  always @(posedge clock) begin : model
    int sel, j;
    int np [N];
    int no [N];
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] <= 0;
        m_ovr[i]  <= 0;
      end
      m_valid <= 0;
      m_id    <= 0;
      m_ptr   <= 0;
    end else begin
      sel = -1;
      if (m_valid == 0 || ready) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (sel < 0 && m_pend[j] != 0) sel = j;
        end
      end
      for (int i = 0; i < N; i++) begin
        np[i] = m_pend[i];
        no[i] = clear_overrun ? 0 : m_ovr[i];
        if (pulse_in[i]) begin
          if (m_pend[i] != 0 && i != sel) no[i] = 1;
          np[i] = 1;
        end else if (i == sel) begin
          np[i] = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        m_pend[i] <= np[i];
        m_ovr[i]  <= no[i];
      end
      if (m_valid == 0 || ready) begin
        if (sel >= 0) begin
          m_valid <= 1;
          m_id    <= sel;
          m_ptr   <= (sel + 1) % N;
        end else begin
          m_valid <= 0;
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int model_ovr();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_ovr[i] != 0) v |= (1 << i);
    return v;
  endfunction

  always @(negedge clock) begin
    if (en) begin
      check("cmp_valid", int'(valid), m_valid);
      if (m_valid != 0) check("cmp_id", int'(id), m_id);
      check("cmp_overrun", int'(overrun), model_ovr());
    end
  end

  task automatic step(input logic [N-1:0] p, input logic r,
                      input logic c = 1'b0, input logic rs = 1'b0);
    pulse_in = p;
    ready = r;
    clear_overrun = c;
    reset = rs;
    @(posedge clock);
    #1;
  endtask

  // Literal expectation on DUT outputs and on the model slot state.
  task automatic expect_out(input string nm, input int v, input int i, input int o);
    check({nm, "_valid"}, int'(valid), v);
    if (v != 0) check({nm, "_id"}, int'(id), i);
    check({nm, "_overrun"}, int'(overrun), o);
    check({nm, "_model_valid"}, m_valid, v);
  endtask

  initial begin
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    check("reset_id", int'(id), 0);
    expect_out("reset", 0, 0, 0);

    // Single event
    step(4'b0100, 1'b1);
    expect_out("single_c1", 0, 0, 0);
    step(4'b0000, 1'b1);
    expect_out("single_c2", 1, 2, 0);
    step(4'b0000, 1'b1);
    expect_out("single_c3", 0, 0, 0);

    // Round robin from ptr=0
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    step(4'b1111, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(4'b0000, 1'b1);
      expect_out("rr_all", 1, k, 0);
    end
    step(4'b0000, 1'b1);
    expect_out("rr_all_done", 0, 0, 0);
    step(4'b0011, 1'b1);
    step(4'b0000, 1'b1);
    expect_out("rr_01_a", 1, 0, 0);
    step(4'b0000, 1'b1);
    expect_out("rr_01_b", 1, 1, 0);
    step(4'b1001, 1'b1);
    expect_out("rr_wrap_gap", 0, 0, 0);
    step(4'b0000, 1'b1);
    expect_out("rr_wrap_a", 1, 3, 0);
    step(4'b0000, 1'b1);
    expect_out("rr_wrap_b", 1, 0, 0);
    step(4'b0000, 1'b1);
    expect_out("rr_wrap_done", 0, 0, 0);

    // Backpressure
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(4'b0000, 1'b0);
      expect_out("bp_stall", 1, 0, 0);
    end
    step(4'b0000, 1'b1);
    expect_out("bp_next", 1, 1, 0);
    step(4'b0000, 1'b1);
    expect_out("bp_done", 0, 0, 0);

    // Overrun with slot holding input 1
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    expect_out("ovr_slot", 1, 1, 0);
    step(4'b0010, 1'b0);
    expect_out("ovr_first_no_flag", 1, 1, 0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    expect_out("ovr_set", 1, 1, 2);
    step(4'b0000, 1'b1);
    expect_out("ovr_reload", 1, 1, 2);
    step(4'b0000, 1'b1);
    expect_out("ovr_single", 0, 0, 2);
    step(4'b0000, 1'b0, 1'b1);
    expect_out("ovr_clear", 0, 0, 0);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    expect_out("ovr_set_wins", 1, 1, 2);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    expect_out("ovr_drained", 0, 0, 0);

    // Same-cycle replace on input 3
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    expect_out("repl_first", 1, 3, 0);
    step(4'b0000, 1'b1);
    expect_out("repl_second", 1, 3, 0);
    step(4'b0000, 1'b1);
    expect_out("repl_done", 0, 0, 0);

    // Reset mid-operation
    step(4'b0001, 1'b0);
    step(4'b0110, 1'b0);
    expect_out("rst_mid_pre", 1, 0, 0);
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    check("rst_mid_id", int'(id), 0);
    expect_out("rst_mid", 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 1'b1);
      expect_out("rst_mid_idle", 0, 0, 0);
    end
    // Pulse during reset is lost
    step(4'b0100, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    expect_out("rst_pulse_lost", 0, 0, 0);

    // Mixed soak checked by the model every cycle
    for (int k = 0; k < 300; k++) begin
      step(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 99) == 0));
    end
    step(4'b0000, 1'b0);

    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
